// File: rtl/timer_pkg.sv
// Shared definitions for the timer16 peripheral: register offsets, CTRL/STATUS
// bit positions and datapath widths.
package timer_pkg;

  localparam int DATA_W      = 8;
  localparam int TIMER_WIDTH = 16;

  typedef enum logic [2:0] {
    OFF_CTRL     = 3'd0,
    OFF_PRESCALE = 3'd1,
    OFF_CMP_L    = 3'd2,
    OFF_CMP_H    = 3'd3,
    OFF_CNT_L    = 3'd4,
    OFF_CNT_H    = 3'd5,
    OFF_STATUS   = 3'd6
  } reg_off_e;

  localparam logic [DATA_W-1:0] NUM_REGS = 8'd7;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MATCH_IE = 1;
  localparam int CTRL_OVF_IE   = 2;
  localparam int CTRL_CTC      = 3;

  localparam int STAT_MATCHF = 0;
  localparam int STAT_OVFF   = 1;

endpackage

// File: rtl/timer16_prescaler.sv
// Clock prescaler for timer16: emits a one-cycle tick every div+1 enabled clocks.
module prescaler
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] div,
  output logic              tick
);

  logic [DATA_W-1:0] pcnt;

  // A clear in the same cycle as a terminal count swallows that tick.
  assign tick = en && !clr && (pcnt == div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (!en || clr || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/timer16.sv
// 16-bit bus-mapped timer/counter with prescaler, compare match and overflow IRQs.
// Optional PWM output is built when TIMER_PWM_EN is defined.
module timer16
  import timer_pkg::*;
#(
  parameter logic [DATA_W-1:0] TIMER_ADDRESS = 8'h10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] address,
  input  logic              w_en,
  input  logic              r_en,
  output logic [DATA_W-1:0] dout,
  output logic              irq_match,
`ifdef TIMER_PWM_EN
  output logic              irq_ovf,
  output logic              pwm_out
`else
  output logic              irq_ovf
`endif
);

  logic [3:0]             ctrl;
  logic [DATA_W-1:0]      prescale;
  logic [TIMER_WIDTH-1:0] cmp;
  logic [TIMER_WIDTH-1:0] cnt;
  logic [DATA_W-1:0]      cnt_h_buf;
  logic [DATA_W-1:0]      cnt_h_shadow;
  logic                   matchf;
  logic                   ovff;

  logic [DATA_W-1:0] offset;
  logic [2:0]        off3;
  logic              in_win;
  logic              wr_ctrl, wr_pre, wr_cmp_l, wr_cmp_h, wr_cnt_l, wr_cnt_h, wr_stat;
  logic              rd_cnt_l;
  logic              tick;
  logic              cmp_hit, ctc_clr, ovf_hit;
  logic [TIMER_WIDTH-1:0] cnt_next;
  logic [DATA_W-1:0] rdata;

  assign offset = address - TIMER_ADDRESS;
  assign off3   = offset[2:0];
  assign in_win = (offset < NUM_REGS);

  assign wr_ctrl  = w_en && in_win && (off3 == OFF_CTRL);
  assign wr_pre   = w_en && in_win && (off3 == OFF_PRESCALE);
  assign wr_cmp_l = w_en && in_win && (off3 == OFF_CMP_L);
  assign wr_cmp_h = w_en && in_win && (off3 == OFF_CMP_H);
  assign wr_cnt_l = w_en && in_win && (off3 == OFF_CNT_L);
  assign wr_cnt_h = w_en && in_win && (off3 == OFF_CNT_H);
  assign wr_stat  = w_en && in_win && (off3 == OFF_STATUS);
  assign rd_cnt_l = r_en && in_win && (off3 == OFF_CNT_L);

  prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl[CTRL_EN]),
    .clr   (wr_pre),
    .div   (prescale),
    .tick  (tick)
  );

  // A bus load of the counter overrides the tick: no match, no overflow.
  assign cmp_hit  = tick && !wr_cnt_l && (cnt == cmp);
  assign ctc_clr  = cmp_hit && ctrl[CTRL_CTC];
  assign ovf_hit  = tick && !wr_cnt_l && !ctc_clr && (cnt == 16'hFFFF);
  assign cnt_next = ctc_clr ? '0 : cnt + 16'd1;

  always_comb begin
    rdata = '0;
    case (off3)
      OFF_CTRL:     rdata = {4'b0000, ctrl};
      OFF_PRESCALE: rdata = prescale;
      OFF_CMP_L:    rdata = cmp[7:0];
      OFF_CMP_H:    rdata = cmp[15:8];
      OFF_CNT_L:    rdata = cnt[7:0];
      OFF_CNT_H:    rdata = cnt_h_shadow;
      OFF_STATUS:   rdata = {6'b000000, ovff, matchf};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl         <= '0;
      prescale     <= '0;
      cmp          <= '0;
      cnt          <= '0;
      cnt_h_buf    <= '0;
      cnt_h_shadow <= '0;
      matchf       <= 1'b0;
      ovff         <= 1'b0;
      irq_match    <= 1'b0;
      irq_ovf      <= 1'b0;
    end else begin
      if (wr_ctrl)  ctrl        <= din[3:0];
      if (wr_pre)   prescale    <= din;
      if (wr_cmp_l) cmp[7:0]    <= din;
      if (wr_cmp_h) cmp[15:8]   <= din;
      if (wr_cnt_h) cnt_h_buf   <= din;
      if (rd_cnt_l) cnt_h_shadow <= cnt[15:8];

      if (wr_cnt_l) begin
        cnt <= {cnt_h_buf, din};
      end else if (tick) begin
        cnt <= cnt_next;
      end

      // A new event outranks a simultaneous write-1-to-clear.
      matchf <= (matchf & ~(wr_stat & din[STAT_MATCHF])) | cmp_hit;
      ovff   <= (ovff   & ~(wr_stat & din[STAT_OVFF]))   | ovf_hit;

      irq_match <= cmp_hit && ctrl[CTRL_MATCH_IE];
      irq_ovf   <= ovf_hit && ctrl[CTRL_OVF_IE];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else begin
      dout <= (r_en && in_win) ? rdata : '0;
    end
  end

`ifdef TIMER_PWM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= ctrl[CTRL_EN] && (cnt < cmp);
    end
  end
`endif

endmodule
